// File: rtl/rob_ptr_ctrl_pkg.sv
// Shared ROB sizing, pointer/count bus types and the occupancy-count update
// encoding used by the allocation/commit controller.
package rob_ptr_ctrl_pkg;

   localparam int ROB_ADDR_WIDTH = 4;
   localparam int ROB_DEPTH      = 2 ** ROB_ADDR_WIDTH;
   localparam int ROB_WB_PORTS   = 2;

   typedef logic [ROB_ADDR_WIDTH-1:0] rob_addr_bus_t;
   typedef logic [ROB_ADDR_WIDTH:0]   rob_ptr_bus_t;
   typedef logic [ROB_ADDR_WIDTH:0]   rob_count_bus_t;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2
   } cnt_op_e;

   // Allocate-only grows the buffer, commit-only shrinks it, both or neither hold.
   function automatic cnt_op_e cnt_op_decode(input logic alloc_fire, input logic commit_fire);
      cnt_op_e op;
      case ({alloc_fire, commit_fire})
         2'b10:   op = CNT_INC;
         2'b01:   op = CNT_DEC;
         default: op = CNT_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rob_status_bits.sv
// Per-entry valid/done bitmap of the reorder buffer. Within one update,
// writeback sets apply first, then the commit clear, then the allocate set.
module rob_status_bits
   import rob_ptr_ctrl_pkg::*;
#(
   parameter int AW       = ROB_ADDR_WIDTH,
   parameter int WB_PORTS = ROB_WB_PORTS
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   set_en_i,
   input  logic [AW-1:0]          set_idx_i,
   input  logic                   clr_en_i,
   input  logic [AW-1:0]          clr_idx_i,
   input  logic [WB_PORTS-1:0]    done_set_en_i,
   input  logic [WB_PORTS*AW-1:0] done_set_idx_i,
   output logic [(2**AW)-1:0]     valid_o,
   output logic [(2**AW)-1:0]     done_o
);

   localparam int DEPTH = 2 ** AW;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] done_q,  done_d;

   // Next-state bitmap: allocation applied last so it overrides a colliding writeback.
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      if (flush_i) begin
         valid_d = {DEPTH{1'b0}};
         done_d  = {DEPTH{1'b0}};
      end else begin
         for (int p = 0; p < WB_PORTS; p++) begin
            done_d[done_set_idx_i[p*AW +: AW]] = done_d[done_set_idx_i[p*AW +: AW]] | done_set_en_i[p];
         end
         valid_d[clr_idx_i] = valid_d[clr_idx_i] & ~clr_en_i;
         done_d[clr_idx_i]  = done_d[clr_idx_i]  & ~clr_en_i;
         valid_d[set_idx_i] = valid_d[set_idx_i] | set_en_i;
         done_d[set_idx_i]  = done_d[set_idx_i]  & ~set_en_i;
      end
   end

   // Bitmap registers, synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= {DEPTH{1'b0}};
         done_q  <= {DEPTH{1'b0}};
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign valid_o = valid_q;
   assign done_o  = done_q;

endmodule

// File: rtl/rob_ptr_ctrl.sv
// Reorder-buffer allocation/commit controller: head/tail pointers with wrap bit,
// occupancy count, writeback completion tracking and ROB-stage handshake decode.
module rob_ptr_ctrl
   import rob_ptr_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
   parameter int WB_PORTS   = ROB_WB_PORTS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           alloc_en,
   output logic                           can_alloc,
   output logic [ADDR_WIDTH-1:0]          alloc_addr,
   input  logic [WB_PORTS-1:0]            wb_valid,
   input  logic [WB_PORTS*ADDR_WIDTH-1:0] wb_addr,
   input  logic                           commit_en,
   output logic                           can_commit,
   output logic [ADDR_WIDTH-1:0]          commit_addr,
   output logic [ADDR_WIDTH:0]            count,
   output logic                           full,
   output logic                           empty
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   head_q,  head_d;
   logic [ADDR_WIDTH:0]   tail_q,  tail_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] head_idx_s, tail_idx_s;
   logic [DEPTH-1:0]      valid_s, done_s;
   logic [WB_PORTS-1:0]   wb_set_s;
   logic                  full_s, empty_s;
   logic                  can_alloc_s, can_commit_s;
   logic                  alloc_fire_s, commit_fire_s;
   cnt_op_e               cnt_op_s;

   assign head_idx_s = head_q[ADDR_WIDTH-1:0];
   assign tail_idx_s = tail_q[ADDR_WIDTH-1:0];

   // Same index with opposite wrap bits means the tail has lapped the head.
   assign full_s  = (head_idx_s == tail_idx_s) && (head_q[ADDR_WIDTH] != tail_q[ADDR_WIDTH]);
   assign empty_s = (head_q == tail_q);

   // Full is taken from the current state only, so a same-cycle commit cannot free a slot.
   assign can_alloc_s   = !full_s && !flush;
   assign can_commit_s  = valid_s[head_idx_s] && done_s[head_idx_s] && !flush;
   assign alloc_fire_s  = alloc_en && can_alloc_s;
   assign commit_fire_s = commit_en && can_commit_s;
   assign cnt_op_s      = cnt_op_decode(alloc_fire_s, commit_fire_s);

   // Writebacks only count against entries that are currently allocated.
   always_comb begin
      wb_set_s = {WB_PORTS{1'b0}};
      for (int p = 0; p < WB_PORTS; p++) begin
         wb_set_s[p] = wb_valid[p] && valid_s[wb_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] && !flush;
      end
   end

   // Pointer and occupancy next-state; flush returns everything to the reset image.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = PTR_ZERO;
         tail_d  = PTR_ZERO;
         count_d = PTR_ZERO;
      end else begin
         head_d = commit_fire_s ? (head_q + PTR_ONE) : head_q;
         tail_d = alloc_fire_s  ? (tail_q + PTR_ONE) : tail_q;
         case (cnt_op_s)
            CNT_INC: count_d = count_q + PTR_ONE;
            CNT_DEC: count_d = count_q - PTR_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= PTR_ZERO;
         tail_q  <= PTR_ZERO;
         count_q <= PTR_ZERO;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   rob_status_bits #(
      .AW       (ADDR_WIDTH),
      .WB_PORTS (WB_PORTS)
   ) u_status (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .set_en_i       (alloc_fire_s),
      .set_idx_i      (tail_idx_s),
      .clr_en_i       (commit_fire_s),
      .clr_idx_i      (head_idx_s),
      .done_set_en_i  (wb_set_s),
      .done_set_idx_i (wb_addr),
      .valid_o        (valid_s),
      .done_o         (done_s)
   );

   assign can_alloc   = can_alloc_s;
   assign can_commit  = can_commit_s;
   assign alloc_addr  = tail_idx_s;
   assign commit_addr = head_idx_s;
   assign count       = count_q;
   assign full        = full_s;
   assign empty       = empty_s;

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Self-checking bench for rob_ptr_ctrl: behavioural model of the ROB status plus
// a scoreboard of allocated indices that must retire in allocation order.
module tb_rob_ptr_ctrl;

   localparam int AW = 4;
   localparam int D  = 16;
   localparam int WP = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            alloc_en;
   logic            can_alloc;
   logic [AW-1:0]   alloc_addr;
   logic [WP-1:0]   wb_valid;
   logic [WP*AW-1:0] wb_addr;
   logic            commit_en;
   logic            can_commit;
   logic [AW-1:0]   commit_addr;
   logic [AW:0]     count;
   logic            full;
   logic            empty;

   always #5 clk = ~clk;

   rob_ptr_ctrl #(.ADDR_WIDTH(AW), .WB_PORTS(WP)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .alloc_en    (alloc_en),
      .can_alloc   (can_alloc),
      .alloc_addr  (alloc_addr),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .commit_en   (commit_en),
      .can_commit  (can_commit),
      .commit_addr (commit_addr),
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

   int n_checks  = 0;
   int n_errors  = 0;
   int n_allocs  = 0;
   int n_commits = 0;

   int m_head, m_tail, m_count;
   bit m_valid [D];
   bit m_done  [D];
   int sb_q [$];

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_head = 0; m_tail = 0; m_count = 0;
      for (int i = 0; i < D; i++) begin
         m_valid[i] = 1'b0;
         m_done[i]  = 1'b0;
      end
      sb_q.delete();
   endtask

   task automatic drive(input bit a, input bit c, input bit [1:0] wv, input int a0, input int a1);
      alloc_en  = a;
      commit_en = c;
      wb_valid  = wv;
      wb_addr   = {4'(a1), 4'(a0)};
   endtask

   // One clock: compare outputs mid-cycle against the model, then advance the model.
   task automatic step();
      bit exp_ca, exp_cc, a_fire, c_fire;
      int hi, ti, wa;
      @(negedge clk);
      hi = m_head % D;
      ti = m_tail % D;
      exp_ca = (m_count != D) && !flush;
      exp_cc = m_valid[hi] && m_done[hi] && !flush;
      chk_eq("can_alloc",   can_alloc,   exp_ca);
      chk_eq("can_commit",  can_commit,  exp_cc);
      chk_eq("alloc_addr",  alloc_addr,  ti);
      chk_eq("commit_addr", commit_addr, hi);
      chk_eq("count",       count,       m_count);
      chk_eq("full",        full,        m_count == D);
      chk_eq("empty",       empty,       m_count == 0);
      a_fire = alloc_en && exp_ca;
      c_fire = commit_en && exp_cc;
      if (!rst || flush) begin
         model_clear();
      end else begin
         for (int p = 0; p < WP; p++) begin
            wa = int'(wb_addr[p*AW +: AW]);
            if (wb_valid[p] && m_valid[wa]) m_done[wa] = 1'b1;
         end
         if (c_fire) begin
            n_commits++;
            if (sb_q.size() == 0) chk_eq("sb_underflow", 32'd1, 32'd0);
            else                  chk_eq("commit_order", commit_addr, sb_q.pop_front());
            m_valid[hi] = 1'b0;
            m_done[hi]  = 1'b0;
            m_head  = (m_head + 1) % 32;
            m_count = m_count - 1;
         end
         if (a_fire) begin
            n_allocs++;
            sb_q.push_back(ti);
            m_valid[ti] = 1'b1;
            m_done[ti]  = 1'b0;
            m_tail  = (m_tail + 1) % 32;
            m_count = m_count + 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic flush_cycle();
      flush = 1'b1;
      drive(0, 0, 2'b00, 0, 0);
      step();
      flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_a, base_c;
      rst = 1'b0; flush = 1'b0;
      drive(0, 0, 2'b00, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_clear();

      // reset state
      step();
      chk_eq("rst_can_alloc", can_alloc, 1'b1);
      chk_eq("rst_can_commit", can_commit, 1'b0);
      chk_eq("rst_count", count, 5'd0);
      chk_eq("rst_empty", empty, 1'b1);
      chk_eq("rst_alloc_addr", alloc_addr, 4'd0);
      chk_eq("rst_commit_addr", commit_addr, 4'd0);

      // fill to full, then an ignored 17th allocation
      for (int i = 0; i < D; i++) begin
         chk_eq("fill_addr", alloc_addr, i);
         drive(1, 0, 2'b00, 0, 0);
         step();
      end
      chk_eq("full_flag", full, 1'b1);
      chk_eq("full_can_alloc", can_alloc, 1'b0);
      chk_eq("full_count", count, 5'd16);
      step();
      chk_eq("alloc17_count", count, 5'd16);
      chk_eq("alloc17_tail", alloc_addr, 4'd0);

      // out-of-order writeback, in-order commit
      flush_cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 2'b00, 0, 0);
         step();
      end
      drive(0, 0, 2'b10, 0, 2);
      step();
      chk_eq("wb2_no_commit", can_commit, 1'b0);
      drive(0, 0, 2'b01, 0, 0);
      step();
      chk_eq("wb0_commit_next", can_commit, 1'b1);
      drive(0, 1, 2'b00, 0, 0);
      step();
      chk_eq("after_c0_wait", can_commit, 1'b0);
      drive(0, 1, 2'b00, 0, 0);
      step();
      chk_eq("c1_blocked_head", commit_addr, 4'd1);
      drive(0, 0, 2'b01, 1, 0);
      step();
      chk_eq("wb1_commit_ready", can_commit, 1'b1);
      drive(0, 1, 2'b00, 0, 0);
      step();
      step();
      chk_eq("ooo_empty", empty, 1'b1);
      chk_eq("ooo_head", commit_addr, 4'd3);

      // steady stream: 40 allocations, pointers wrap twice
      flush_cycle();
      base_a = n_allocs; base_c = n_commits;
      for (int cyc = 0; cyc < 400 && (n_allocs - base_a) < 40; cyc++) begin
         drive(1, 1, 2'b11, m_head % D, (m_head + 1) % D);
         step();
      end
      chk_eq("stream_allocs", n_allocs - base_a, 40);
      for (int cyc = 0; cyc < 100 && m_count != 0; cyc++) begin
         drive(0, 1, 2'b11, m_head % D, (m_head + 1) % D);
         step();
      end
      chk_eq("stream_drained", empty, 1'b1);
      chk_eq("stream_commits", n_commits - base_c, 40);
      chk_eq("stream_tail", alloc_addr, 4'd8);

      // random traffic against the model
      for (int cyc = 0; cyc < 300; cyc++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
               $urandom_range(0, D - 1), $urandom_range(0, D - 1));
         step();
      end

      // full + head done: commit accepted, same-cycle alloc refused
      flush_cycle();
      for (int i = 0; i < D; i++) begin
         drive(1, 0, (i == 5) ? 2'b01 : 2'b00, 0, 0);
         step();
      end
      chk_eq("fc_full", full, 1'b1);
      chk_eq("fc_can_commit", can_commit, 1'b1);
      drive(1, 1, 2'b00, 0, 0);
      step();
      chk_eq("fc_count15", count, 5'd15);
      chk_eq("fc_alloc_addr", alloc_addr, 4'd0);
      drive(1, 0, 2'b00, 0, 0);
      step();
      chk_eq("fc_count16", count, 5'd16);
      chk_eq("fc_full_again", full, 1'b1);

      // flush and then mid-stream reset with all strobes active
      for (int mode = 0; mode < 2; mode++) begin
         flush_cycle();
         for (int i = 0; i < 5; i++) begin
            drive(1, 0, 2'b00, 0, 0);
            step();
         end
         drive(0, 0, 2'b11, 0, 1);
         step();
         chk_eq("pre_kill_cc", can_commit, 1'b1);
         drive(1, 1, 2'b11, 2, 3);
         if (mode == 0) flush = 1'b1;
         else           rst   = 1'b0;
         #1;
         if (mode == 0) begin
            chk_eq("flush_can_alloc", can_alloc, 1'b0);
            chk_eq("flush_can_commit", can_commit, 1'b0);
         end
         step();
         flush = 1'b0;
         rst   = 1'b1;
         drive(0, 0, 2'b00, 0, 0);
         chk_eq("kill_count", count, 5'd0);
         chk_eq("kill_empty", empty, 1'b1);
         chk_eq("kill_alloc_addr", alloc_addr, 4'd0);
         chk_eq("kill_commit_addr", commit_addr, 4'd0);
         drive(1, 0, 2'b00, 0, 0);
         step();
         drive(0, 0, 2'b00, 0, 0);
         step();
         chk_eq("kill_no_done", can_commit, 1'b0);
         chk_eq("kill_count1", count, 5'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rob_ptr_ctrl.md
Name: rob_ptr_ctrl

Overview:
Allocation and commit controller for the reorder buffer. It owns the circular head/tail pointers and the per-entry valid/done status bits, and it records writeback completions. It generates the rob_can_write, rob_write_addr_in and rob_can_commit signals consumed by the ROB stage. Payload storage stays in the separate ROB RAM, which is indexed by alloc_addr and commit_addr.

Parameters:
ADDR_WIDTH, 4, ROB index width; depth DEPTH = 2**ADDR_WIDTH (16)
WB_PORTS, 2, number of writeback completion ports

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-low
flush  in  1  pipeline flush on exception/redirect; discards all entries
alloc_en  in  1  allocate one entry this cycle (ROB stage rob_write_en)
can_alloc  out  1  an entry is free (to ROB stage rob_can_write)
alloc_addr  out  ADDR_WIDTH  index of the entry to allocate (tail)
wb_valid  in  WB_PORTS  per-port completion strobe
wb_addr  in  WB_PORTS*ADDR_WIDTH  per-port completed entry index, port i at bits [i*AW +: AW]
commit_en  in  1  retire the head entry (ROB stage rob_commit_en)
can_commit  out  1  head entry is valid and done
commit_addr  out  ADDR_WIDTH  index of the head entry
count  out  ADDR_WIDTH+1  number of occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- State:
  - head_q, tail_q are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - count_q is ADDR_WIDTH+1 bits.
  - valid_q[DEPTH] and done_q[DEPTH] hold per-entry status.
- Full/empty decode:
  - full when the pointer indices are equal and the wrap bits differ.
  - empty when head_q == tail_q.
  - count_q must always equal tail_q - head_q modulo 2**(ADDR_WIDTH+1).
- Reset (rst==0 at posedge): head_q=tail_q=0, count_q=0, all valid/done cleared. Resulting outputs:
  - can_alloc=1, can_commit=0
  - alloc_addr=0, commit_addr=0, count=0
  - full=0, empty=1
- Reset mid-operation discards every entry exactly as flush does, and reset dominates all other inputs.
- Combinational outputs:
  - can_alloc = !full && !flush
  - can_commit = valid_q[head] && done_q[head] && !flush
  - alloc_addr = tail_q[AW-1:0]
  - commit_addr = head_q[AW-1:0]
- Allocate (alloc_en && can_alloc):
  - valid[tail]=1, done[tail]=0, tail_q+=1; the index wraps DEPTH-1 -> 0 and the wrap bit toggles.
  - alloc_en while !can_alloc is ignored and changes no state.
- Writeback, per port i: if wb_valid[i] and valid_q[wb_addr_i], set done[wb_addr_i]=1.
  - A writeback to an invalid entry is ignored.
  - Two ports naming the same entry in one cycle is legal; the result is a single set.
- Writeback-to-commit latency is 1 cycle: done set at edge N makes can_commit visible in cycle N+1. There is no same-cycle bypass.
- Commit (commit_en && can_commit): valid[head]=0, done[head]=0, head_q+=1 with wrap.
  - commit_en while !can_commit is ignored.
- Count update:
  - +1 on allocate only, -1 on commit only.
  - Unchanged when both allocate and commit occur in the same cycle.
- Full boundary:
  - While full, can_alloc=0 even if a commit happens the same cycle; there is no commit-to-alloc bypass.
  - Allocation resumes in the cycle after the commit.
- Empty boundary: simultaneous alloc and commit cannot occur, because can_commit=0 while the head entry is invalid.
- Alloc/writeback collision: if an allocation and a writeback target the same index in one cycle, the allocation wins and done ends at 0.
- Flush (rst==1, flush==1):
  - Next state: head_q=tail_q=0, count_q=0, all valid/done cleared.
  - Alloc, commit and writeback that cycle are all discarded.
  - can_alloc and can_commit are forced to 0 during the flush cycle.
  - Post-flush state equals the reset state.

Decomposition:
- Shared package rob.v:
  - ROB_ADDR_WIDTH (4), ROB_DEPTH (16)
  - ROB_ADDR_BUS (ROB_ADDR_WIDTH-1:0)
  - ROB_PTR_BUS (ROB_ADDR_WIDTH:0), ROB_COUNT_BUS (ROB_ADDR_WIDTH:0)
- Sub-module rob_status_bits holds the valid/done bitmap.
  - Inputs: set-valid index/strobe, clear index/strobe, WB_PORTS done-set strobes, flush, rst.
  - Outputs: valid/done vectors.
  - rob_ptr_ctrl keeps the pointers, count, priority rules and output decode.

Test Plan:
- Reset then idle -> can_alloc=1, can_commit=0, count=0, empty=1, alloc_addr=0, commit_addr=0.
- 16 back-to-back allocs -> alloc_addr steps 0..15, then full=1, can_alloc=0, count=16; a 17th alloc_en leaves tail and count unchanged.
- Alloc entries 0,1,2; wb port1 completes 2, then port0 completes 0 -> can_commit=1 one cycle after entry 0's writeback.
  - Commit 0; can_commit stays 0 until entry 1's writeback, then commits 1 and 2 in order.
- Steady stream of 40 alloc+wb+commit -> pointers wrap twice, commit order equals alloc order, and count matches tail-head every cycle.
- Full buffer with head done; assert commit_en and alloc_en in the same cycle -> commit occurs, alloc is ignored, and count goes 16->15.
  - Next cycle: alloc accepted at addr = old head index, count back to 16.
- 5 entries, 2 done; flush with simultaneous alloc_en, commit_en and wb_valid -> can_alloc=can_commit=0 that cycle.
  - Next cycle: count=0, empty=1, pointers 0, no entry valid.
  - Repeat the same check with rst=0 asserted mid-stream.
